// File: rtl/video_pkg.sv
// Shared constants and types for the video capture block and its CRC helper.
package video_pkg;

   localparam int H_ACTIVE_DEF = 320;
   localparam int V_ACTIVE_DEF = 240;
   localparam int ADDR_W_DEF   = 17;

   // Source pixel/line counters saturate at their all-ones value.
   localparam int CNT_W = 11;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_FRAME = 2'd1,
      CAPTURE    = 2'd2,
      DONE       = 2'd3
   } cap_state_t;

endpackage

// File: rtl/crc16_ccitt_8b.sv
// CRC-16/CCITT (MSB first, no reflection) register advanced one byte per enabled cycle.
module crc16_ccitt_8b
   import video_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);

   function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) begin
         r = r[15] ? ({r[14:0], 1'b0} ^ CRC_POLY) : {r[14:0], 1'b0};
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc <= '0;
      end else if (init) begin
         crc <= CRC_INIT;
      end else if (en) begin
         crc <= crc_next(crc, data);
      end
   end

endmodule

// File: rtl/video_capture.sv
// Video capture: decodes vs/blank timing and stores one armed frame of RGB332 pixels into VRAM.
// Build macro VIDEO_CAPTURE_CRC_EN adds a CRC-16/CCITT over every written pixel on the crc port.
module video_capture
   import video_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int ADDR_W   = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              hs,
   input  logic              vs,
   input  logic              blank,
   input  logic [7:0]        pix,
   input  logic              decimate,
   input  logic              arm,
   output logic              busy,
   output logic              frame_done,
   output logic              err,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [15:0]       crc
);

   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   cap_state_t        state, state_d;
   logic              vs_p0, vs_d1, blank_p0, blank_d1, arm_p0, dec_p0;
   logic [7:0]        pix_p0;
   logic              dec_lat;
   logic [CNT_W-1:0]  sx, sy, ox, oy, lines_kept;
   logic [ADDR_W-1:0] line_base;
   logic              vs_fall, line_end, start, row_kept, row_adv;
   logic              keep, in_range, write;
   logic              unused_hs;

   // hs carries no timing that blank does not already provide for capture.
   assign unused_hs = hs;

   // Stage p0: every input passes through one register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_p0    <= 1'b1;
         vs_d1    <= 1'b1;
         blank_p0 <= 1'b1;
         blank_d1 <= 1'b1;
         arm_p0   <= 1'b0;
         dec_p0   <= 1'b0;
         pix_p0   <= '0;
      end else begin
         vs_p0    <= vs;
         vs_d1    <= vs_p0;
         blank_p0 <= blank;
         blank_d1 <= blank_p0;
         arm_p0   <= arm;
         dec_p0   <= decimate;
         pix_p0   <= pix;
      end
   end

   assign vs_fall  = vs_d1 & ~vs_p0;
   assign line_end = blank_p0 & ~blank_d1;
   assign start    = (state == WAIT_FRAME) & vs_fall;

   assign ox       = dec_lat ? (sx >> 1) : sx;
   assign oy       = dec_lat ? (sy >> 1) : sy;
   // A line is stored when it lands on an even source row; oy advances after odd rows.
   assign row_kept = ~dec_lat | ~sy[0];
   assign row_adv  = ~dec_lat | sy[0];

   assign keep     = (state == CAPTURE) & ~blank_p0 & (~dec_lat | (~sx[0] & ~sy[0]));
   assign in_range = (int'(ox) < H_ACTIVE) & (int'(oy) < V_ACTIVE);
   assign write    = keep & in_range;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:       if (arm_p0)  state_d = WAIT_FRAME;
         WAIT_FRAME: if (vs_fall) state_d = CAPTURE;
         CAPTURE:    if (vs_fall) state_d = DONE;
         DONE:                    state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dec_lat <= 1'b0;
      end else if ((state == IDLE) && arm_p0) begin
         dec_lat <= dec_p0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sx         <= '0;
         sy         <= '0;
         lines_kept <= '0;
         line_base  <= '0;
      end else if (start) begin
         sx         <= '0;
         sy         <= '0;
         lines_kept <= '0;
         line_base  <= '0;
      end else if (state == CAPTURE) begin
         if (!blank_p0) begin
            sx <= sat_inc(sx);
         end else if (line_end) begin
            sx <= '0;
            sy <= sat_inc(sy);
            if (row_kept) begin
               lines_kept <= sat_inc(lines_kept);
            end
            // Base stops moving once past the last stored line, so it never wraps into range.
            if (row_adv && (int'(oy) < V_ACTIVE)) begin
               line_base <= line_base + H_STEP;
            end
         end
      end
   end

   // Stage p1: VRAM write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         wr_en <= write;
         if (write) begin
            wr_addr <= line_base + ADDR_W'(ox);
            wr_data <= pix_p0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err <= 1'b0;
      end else if ((state == IDLE) && arm_p0) begin
         err <= 1'b0;
      end else if (keep && !in_range) begin
         err <= 1'b1;
      end else if ((state == CAPTURE) && vs_fall && (int'(lines_kept) != V_ACTIVE)) begin
         err <= 1'b1;
      end
   end

`ifdef VIDEO_CAPTURE_CRC_EN
   crc16_ccitt_8b u_crc (
      .clk     (clk),
      .reset_n (reset_n),
      .init    (start),
      .en      (wr_en),
      .data    (wr_data),
      .crc     (crc)
   );
`else
   assign crc = '0;
`endif

endmodule
